// File: rtl/beam_sum_sequencer.sv
// rtl/beam_sum_sequencer.sv - time-multiplexed N_CH-sample frame accumulator for the beamformer
//
// Purpose : Replaces the parallel summing tree by taking one channel sample per beat over a
//           valid/ready stream. N_CH samples are added through a single W-bit adder, and the
//           frame sum is then held on a valid/ready output handshake.
// Ports   : clk, rst (async, active-high)
//           start     - begin a frame (taken in IDLE, or in HOLD on the output handshake cycle)
//           abort     - drop the current frame and return to IDLE (highest priority)
//           in_valid / in_ready / in_data   - sample stream, channel order 0..N_CH-1
//           out_valid / out_ready / out_sum / out_carry - frame result handshake
//           busy      - engine is not idle
// Config  : SATURATE_EN defined   -> the accumulator clamps to 2^W-1 on the first carry.
//           SATURATE_EN undefined -> the accumulator wraps modulo 2^W.
//           In both builds out_carry is a sticky carry flag for the frame.

module beam_sum_sequencer #(
    parameter int N_CH = 16,
    parameter int W    = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_carry,
    output logic         busy
);

    localparam int CW = $clog2(N_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          carry;

    logic          clear;
    logic          accept;
    logic [W:0]    sum_ext;
    logic [W-1:0]  acc_nx;
    logic          carry_nx;

    // Next-state decode. abort is checked before anything else so it also suppresses
    // an output handshake or a start that arrives in the same cycle.
    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        accept   = 1'b0;
        if (abort) begin
            state_nx = IDLE;
            clear    = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nx = ACCUM;
                        clear    = 1'b1;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        accept = 1'b1;
                        if (cnt == CW'(N_CH - 1)) begin
                            state_nx = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (start) begin
                            // Back-to-back frame: skip the IDLE bubble.
                            state_nx = ACCUM;
                            clear    = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                    clear    = 1'b1;
                end
            endcase
        end
    end

    // Single shared adder; the extra top bit is the carry-out of this beat.
    always_comb begin
        sum_ext  = {1'b0, acc} + {1'b0, in_data};
        carry_nx = carry | sum_ext[W];
`ifdef SATURATE_EN
        // Once clamped the accumulator stays at full scale for the rest of the frame.
        acc_nx   = (carry | sum_ext[W]) ? {W{1'b1}} : sum_ext[W-1:0];
`else
        acc_nx   = sum_ext[W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            // Handshake flags are loaded from the next state so they are true flops
            // that line up exactly with the state register.
            in_ready  <= (state_nx == ACCUM);
            out_valid <= (state_nx == HOLD);
            busy      <= (state_nx != IDLE);
            if (clear) begin
                acc   <= '0;
                cnt   <= '0;
                carry <= 1'b0;
            end else if (accept) begin
                acc   <= acc_nx;
                carry <= carry_nx;
                // cnt stops at N_CH-1: the final beat moves to HOLD instead of wrapping.
                if (cnt != CW'(N_CH - 1)) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign out_sum   = acc;
    assign out_carry = carry;

endmodule
